// File: rtl/iob_rr_merge_pkg.sv
// Shared types for the round-robin IOb merge: controller state encoding.
package iob_rr_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/iob_rr_merge_prio_enc.sv
// Rotating priority encoder: picks the first requester at or after (last+1) mod N.
module iob_rr_merge_prio_enc #(
    parameter  int N  = 2,
    localparam int NB = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [NB-1:0] last_i,
    output logic [NB-1:0] grant_o,
    output logic          any_o
);

    // Walk the slots starting just after the last winner, wrapping at N; the first hit wins.
    always_comb begin
        logic [NB-1:0] v_idx;
        logic          v_found;
        v_idx   = '0;
        v_found = 1'b0;
        grant_o = '0;
        for (int i = 0; i < N; i++) begin
            v_idx   = NB'((int'(last_i) + 32'sd1 + i) % N);
            grant_o = (!v_found && req_i[v_idx]) ? v_idx : grant_o;
            v_found = v_found | req_i[v_idx];
        end
        any_o = v_found;
    end

endmodule

// File: rtl/iob_rr_merge.sv
// Round-robin merge of N IOb native masters onto one follower, one transaction in flight.
module iob_rr_merge
    import iob_rr_merge_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int N      = 2,
    localparam int NB     = $clog2(N),
    localparam int SW     = DATA_W / 8
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,
    input  logic [N-1:0]        m_avalid_i,
    input  logic [N*ADDR_W-1:0] m_addr_i,
    input  logic [N*DATA_W-1:0] m_wdata_i,
    input  logic [N*SW-1:0]     m_wstrb_i,
    output logic [DATA_W-1:0]   m_rdata_o,
    output logic [N-1:0]        m_rvalid_o,
    output logic [N-1:0]        m_ready_o,
    output logic                f_avalid_o,
    output logic [ADDR_W-1:0]   f_addr_o,
    output logic [DATA_W-1:0]   f_wdata_o,
    output logic [SW-1:0]       f_wstrb_o,
    input  logic [DATA_W-1:0]   f_rdata_i,
    input  logic                f_rvalid_i,
    input  logic                f_ready_i,
    output logic [NB-1:0]       grant_o
);

    state_t              r_state;
    logic [NB-1:0]       r_grant;
    logic [NB-1:0]       r_last;

    logic [NB-1:0]       w_next_grant;
    logic                w_any_req;
    logic                w_sel_avalid;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [SW-1:0]       w_sel_wstrb;
    logic [N-1:0]        w_grant_oh;

    iob_rr_merge_prio_enc #(.N(N)) u_prio_enc (
        .req_i   (m_avalid_i),
        .last_i  (r_last),
        .grant_o (w_next_grant),
        .any_o   (w_any_req)
    );

    // Select the granted master's request fields and build the one-hot grant used for steering.
    always_comb begin
        w_sel_avalid = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_sel_wstrb  = '0;
        w_grant_oh   = '0;
        for (int k = 0; k < N; k++) begin
            if (r_grant == NB'(k)) begin
                w_sel_avalid  = m_avalid_i[k];
                w_sel_addr    = m_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_wdata   = m_wdata_i[k*DATA_W +: DATA_W];
                w_sel_wstrb   = m_wstrb_i[k*SW +: SW];
                w_grant_oh[k] = 1'b1;
            end else begin
                w_grant_oh[k] = 1'b0;
            end
        end
    end

    // Drive follower request and master handshakes from the current state; fields are zero outside REQ.
    always_comb begin
        f_avalid_o = 1'b0;
        f_addr_o   = '0;
        f_wdata_o  = '0;
        f_wstrb_o  = '0;
        m_ready_o  = '0;
        m_rvalid_o = '0;
        case (r_state)
            ST_REQ: begin
                f_avalid_o = w_sel_avalid;
                f_addr_o   = w_sel_addr;
                f_wdata_o  = w_sel_wdata;
                f_wstrb_o  = w_sel_wstrb;
                m_ready_o  = w_grant_oh & {N{f_ready_i}};
            end
            ST_RDWAIT: begin
                m_rvalid_o = w_grant_oh & {N{f_rvalid_i}};
            end
            default: begin
                m_ready_o  = '0;
                m_rvalid_o = '0;
            end
        endcase
    end

    assign m_rdata_o = f_rdata_i;
    assign grant_o   = r_grant;

    // Arbitration and transaction-tracking FSM; everything holds while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= NB'(N - 1);
        end else if (cke_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_next_grant;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_sel_avalid && f_ready_i) begin
                        r_last  <= r_grant;
                        r_state <= (w_sel_wstrb != '0) ? ST_IDLE : ST_RDWAIT;
                    end else if (!w_sel_avalid) begin
                        // Master withdrew before acceptance: no transfer, fairness pointer untouched.
                        r_state <= ST_IDLE;
                    end
                end
                ST_RDWAIT: begin
                    if (f_rvalid_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
